// File: rtl/scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// scan_decoder_pkg
//   Shared encodings for the scan_decoder block: FSM state encoding and the
//   mode input constants.
//   Build option used elsewhere in this block: SCAN_DEC_IDX_OUT_EN (adds the
//   idx_o port on scan_decoder).
// ---------------------------------------------------------------------------
package scan_decoder_pkg;

  // 2-bit state encoding; 2'b11 is unused and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_decoder_pkg

// File: rtl/scan_decoder_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen
//   Dwell-time divider for the scan rotation. Counts clocks while run=1 and
//   emits a 1-clock tick in the cycle the count sits at PERIOD-1; the count
//   then restarts at 0. clr forces the count back to 0 and suppresses tick.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  synchronous active-low reset (count -> 0)
//     clr    in  synchronous clear, dominates run
//     run    in  count enable
//     tick   out combinational terminal-count strobe
//   Parameters:
//     PERIOD  clocks per tick, >= 1 (PERIOD=1 ticks every running clock)
// ---------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int DIV_W = $clog2(PERIOD) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick = run && !clr && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (run) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule : scan_tick_gen

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//   SEL_W-to-2**SEL_W one-hot decoder with registered output and enable.
//   DIRECT mode decodes sel; SCAN mode rotates the active line every PERIOD
//   clocks, pulsing wrap when the rotation returns from the last line to 0.
//   Drives digit-select / row-strobe lines of multiplexed displays/keypads.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | en=0: all outputs low
//   DIRECT | y = 1<<sel, one clock after sel
//   SCAN   | y rotates through all lines, PERIOD clocks per line
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   synchronous active-low reset, overrides all inputs
//     en     in   0 forces idle (all outputs low)
//     mode   in   0 = DIRECT, 1 = SCAN (only meaningful while en=1)
//     sel    in   line index for DIRECT mode
//     y      out  registered one-hot (or all-zero when idle)
//     wrap   out  1-clock pulse when SCAN moves from line OUT_N-1 to 0
//     idx_o  out  registered SCAN index, 0 outside SCAN
//                 (only when SCAN_DEC_IDX_OUT_EN is defined)
//   Parameters:
//     SEL_W   select width, 1..6; OUT_N = 2**SEL_W output lines
//     PERIOD  clocks each line stays active in SCAN, >= 1
// ---------------------------------------------------------------------------
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W  = 2,
  parameter int PERIOD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [2**SEL_W-1:0] y,
  output logic               wrap
`ifdef SCAN_DEC_IDX_OUT_EN
  ,
  output logic [SEL_W-1:0]   idx_o
`endif
);

  localparam int OUT_N = 2**SEL_W;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_N-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;
  logic             scan_run;
  logic             step_tick;

  // Next-state logic; en=0 dominates mode in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
      end
      ST_DIRECT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (mode == MODE_SCAN) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (mode == MODE_DIRECT) begin
          state_d = ST_DIRECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The divider only runs while we stay in SCAN; entering or leaving SCAN
  // clears it, so a re-entry always dwells a full PERIOD on line 0.
  assign scan_run = (state_q == ST_SCAN) && (state_d == ST_SCAN);

  scan_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!scan_run),
    .run   (scan_run),
    .tick  (step_tick)
  );

  // Output decode keyed on the state being entered, so a mode change on a
  // step edge takes the new mode's action and the pending step is dropped.
  always_comb begin
    idx_d  = '0;
    y_d    = '0;
    wrap_d = 1'b0;
    case (state_d)
      ST_DIRECT: begin
        y_d[sel] = 1'b1;
      end
      ST_SCAN: begin
        if (!scan_run) begin
          y_d[0] = 1'b1;
        end else if (step_tick) begin
          // idx is exactly SEL_W wide, so the increment wraps mod OUT_N.
          idx_d      = idx_q + SEL_W'(1);
          y_d[idx_d] = 1'b1;
          wrap_d     = &idx_q;
        end else begin
          idx_d      = idx_q;
          y_d[idx_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y    = y_q;
  assign wrap = wrap_q;
`ifdef SCAN_DEC_IDX_OUT_EN
  assign idx_o = idx_q;
`endif

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;

  typedef struct {
    logic [7:0] y;
    logic       wrap;
    logic [2:0] idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: SEL_W=2, PERIOD=3
  logic       rst_n, en, mode;
  logic [1:0] sel;
  logic [3:0] y;
  logic       wrap;
  // DUT B: SEL_W=3, PERIOD=1
  logic       rst8_n, en8, mode8;
  logic [2:0] sel8;
  logic [7:0] y8;
  logic       wrap8;
`ifdef SCAN_DEC_IDX_OUT_EN
  logic [1:0] idx;
  logic [2:0] idx8;
`endif

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  scan_decoder #(.SEL_W(2), .PERIOD(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .sel   (sel),
    .y     (y),
    .wrap  (wrap)
`ifdef SCAN_DEC_IDX_OUT_EN
    ,
    .idx_o (idx)
`endif
  );

  scan_decoder #(.SEL_W(3), .PERIOD(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst8_n),
    .en    (en8),
    .mode  (mode8),
    .sel   (sel8),
    .y     (y8),
    .wrap  (wrap8)
`ifdef SCAN_DEC_IDX_OUT_EN
    ,
    .idx_o (idx8)
`endif
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int line, input logic w, input logic on);
    exp_t e;
    e.y    = on ? (8'd1 << line) : 8'd0;
    e.wrap = w;
    e.idx  = on ? 3'(line) : 3'd0;
    return e;
  endfunction

  task automatic test_reset();
    exp_t g;
    for (int i = 0; i < 4; i++) begin
      rst_n = (i >= 2);
      en    = (i < 3);
      mode  = 1'b1;
      sel   = 2'd0;
      exp_q.push_back(mk(0, 1'b0, i == 2));
      step_clk();
      g = exp_q.pop_front();
      n_vec++;
      if (y !== g.y[3:0] || wrap !== g.wrap) begin
        n_err++;
        $display("FAIL reset[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", i, y, wrap, g.y[3:0], g.wrap);
      end
      n_vec++;
      if (y8 !== 8'd0 || wrap8 !== 1'b0) begin
        n_err++;
        $display("FAIL reset8[%0d]: got y=%b wrap=%b, want y=00000000 wrap=0", i, y8, wrap8);
      end
`ifdef SCAN_DEC_IDX_OUT_EN
      n_vec++;
      if (idx !== g.idx[1:0]) begin
        n_err++;
        $display("FAIL reset_idx[%0d]: got %0d, want %0d", i, idx, g.idx[1:0]);
      end
`endif
      if (i == 1) rst8_n = 1'b1;
    end
  endtask

  task automatic test_direct();
    exp_t g;
    for (int i = 0; i < 5; i++) begin
      en   = (i < 4);
      mode = 1'b0;
      sel  = 2'(i);
      exp_q.push_back(mk(i, 1'b0, i < 4));
      step_clk();
      g = exp_q.pop_front();
      n_vec++;
      if (y !== g.y[3:0] || wrap !== g.wrap) begin
        n_err++;
        $display("FAIL direct[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", i, y, wrap, g.y[3:0], g.wrap);
      end
`ifdef SCAN_DEC_IDX_OUT_EN
      n_vec++;
      if (idx !== 2'd0) begin
        n_err++;
        $display("FAIL direct_idx[%0d]: got %0d, want 0", i, idx);
      end
`endif
    end
  endtask

  task automatic test_scan();
    exp_t g;
    for (int k = 0; k < 16; k++) begin
      en   = (k < 15);
      mode = 1'b1;
      sel  = 2'd3;
      exp_q.push_back(mk((k / 3) % 4, k == 12, k < 15));
      step_clk();
      g = exp_q.pop_front();
      n_vec++;
      if (y !== g.y[3:0] || wrap !== g.wrap) begin
        n_err++;
        $display("FAIL scan[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", k, y, wrap, g.y[3:0], g.wrap);
      end
`ifdef SCAN_DEC_IDX_OUT_EN
      n_vec++;
      if (idx !== g.idx[1:0]) begin
        n_err++;
        $display("FAIL scan_idx[%0d]: got %0d, want %0d", k, idx, g.idx[1:0]);
      end
`endif
    end
  endtask

  task automatic test_period1();
    exp_t g;
    for (int k = 0; k < 19; k++) begin
      en8   = (k < 18);
      mode8 = 1'b1;
      sel8  = 3'd5;
      exp_q.push_back(mk(k % 8, (k > 0) && (k % 8 == 0), k < 18));
      step_clk();
      g = exp_q.pop_front();
      n_vec++;
      if (y8 !== g.y || wrap8 !== g.wrap) begin
        n_err++;
        $display("FAIL period1[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", k, y8, wrap8, g.y, g.wrap);
      end
`ifdef SCAN_DEC_IDX_OUT_EN
      n_vec++;
      if (idx8 !== g.idx) begin
        n_err++;
        $display("FAIL period1_idx[%0d]: got %0d, want %0d", k, idx8, g.idx);
      end
`endif
    end
  endtask

  // Mode change to DIRECT exactly on the edge that would have wrapped.
  task automatic test_mode_switch();
    exp_t g;
    for (int k = 0; k < 18; k++) begin
      en   = (k < 17);
      mode = (k != 12);
      sel  = (k == 12) ? 2'd2 : 2'd3;
      if (k < 12)       exp_q.push_back(mk(k / 3, 1'b0, 1'b1));
      else if (k == 12) exp_q.push_back(mk(2, 1'b0, 1'b1));
      else if (k < 16)  exp_q.push_back(mk(0, 1'b0, 1'b1));
      else if (k == 16) exp_q.push_back(mk(1, 1'b0, 1'b1));
      else              exp_q.push_back(mk(0, 1'b0, 1'b0));
      step_clk();
      g = exp_q.pop_front();
      n_vec++;
      if (y !== g.y[3:0] || wrap !== g.wrap) begin
        n_err++;
        $display("FAIL mode_switch[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", k, y, wrap, g.y[3:0], g.wrap);
      end
`ifdef SCAN_DEC_IDX_OUT_EN
      n_vec++;
      if (idx !== ((k == 12) ? 2'd0 : g.idx[1:0])) begin
        n_err++;
        $display("FAIL mode_switch_idx[%0d]: got %0d, want %0d", k, idx, (k == 12) ? 2'd0 : g.idx[1:0]);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    exp_t g;
    for (int k = 0; k < 13; k++) begin
      rst_n = (k != 7);
      en    = (k < 12);
      mode  = 1'b1;
      sel   = 2'd1;
      if (k < 7)       exp_q.push_back(mk(k / 3, 1'b0, 1'b1));
      else if (k == 7) exp_q.push_back(mk(0, 1'b0, 1'b0));
      else if (k < 11) exp_q.push_back(mk(0, 1'b0, 1'b1));
      else if (k == 11) exp_q.push_back(mk(1, 1'b0, 1'b1));
      else             exp_q.push_back(mk(0, 1'b0, 1'b0));
      step_clk();
      g = exp_q.pop_front();
      n_vec++;
      if (y !== g.y[3:0] || wrap !== g.wrap) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", k, y, wrap, g.y[3:0], g.wrap);
      end
`ifdef SCAN_DEC_IDX_OUT_EN
      n_vec++;
      if (idx !== g.idx[1:0]) begin
        n_err++;
        $display("FAIL reset_mid_idx[%0d]: got %0d, want %0d", k, idx, g.idx[1:0]);
      end
`endif
    end
  endtask

  // DIRECT->SCAN entry, en=0 dominating mode, back-to-back DIRECT selects.
  task automatic test_back_to_back();
    exp_t g;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin en = 1'b1; mode = 1'b0; sel = 2'd3; exp_q.push_back(mk(3, 1'b0, 1'b1)); end
        1: begin en = 1'b1; mode = 1'b1; sel = 2'd3; exp_q.push_back(mk(0, 1'b0, 1'b1)); end
        2: begin en = 1'b1; mode = 1'b1; sel = 2'd2; exp_q.push_back(mk(0, 1'b0, 1'b1)); end
        3: begin en = 1'b0; mode = 1'b0; sel = 2'd1; exp_q.push_back(mk(0, 1'b0, 1'b0)); end
        4: begin en = 1'b1; mode = 1'b0; sel = 2'd1; exp_q.push_back(mk(1, 1'b0, 1'b1)); end
        5: begin en = 1'b1; mode = 1'b0; sel = 2'd2; exp_q.push_back(mk(2, 1'b0, 1'b1)); end
        default: begin en = 1'b0; mode = 1'b1; sel = 2'd0; exp_q.push_back(mk(0, 1'b0, 1'b0)); end
      endcase
      step_clk();
      g = exp_q.pop_front();
      n_vec++;
      if (y !== g.y[3:0] || wrap !== g.wrap) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got y=%b wrap=%b, want y=%b wrap=%b", k, y, wrap, g.y[3:0], g.wrap);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd0;
    rst8_n = 1'b0; en8 = 1'b0; mode8 = 1'b0; sel8 = 3'd0;
    test_reset();
    test_direct();
    test_scan();
    test_period1();
    test_mode_switch();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule : tb_scan_decoder
